keypad_fifo_writer: RTL and testbench
=====================================

// Module: keypad_fifo_writer
// PURPOSE
//  Upstream producer for the 16x8 queue: scans a 4x4 matrix keypad, debounces presses, encodes key 0..F
//  and issues one single-cycle insert (CS=1, Insert_Delete=1, Data_In=code) per accepted press.
//  Owns the write side of the queue; the read/delete side is driven elsewhere.
// PARAMETERS
//  DataWide        8      width of fifo_data; code in [3:0], upper bits 0
//  SCAN_DIV        50000  clk cycles per scan tick (column dwell); >=2
//  DEBOUNCE_SCANS  4      consecutive matching ticks to accept press / release; >=1
//  REPEAT_DELAY    50     ticks held before first repeat (KEY_REPEAT_EN only)
//  REPEAT_RATE     10     ticks between repeats (KEY_REPEAT_EN only)
// PORTS
//  clk            in   1         system clock, rising edge
//  rst            in   1         asynchronous, active-low reset
//  kp_row         in   4         keypad rows, active-low (pull-ups), asynchronous to clk
//  kp_col         out  4         keypad column drive, active-low one-hot
//  fifo_full      in   1         queue Full flag
//  fifo_cs        out  1         queue chip select, 1-cycle pulse per write
//  fifo_insert    out  1         queue Insert_Delete; 1 whenever fifo_cs=1, else 0
//  fifo_data      out  DataWide  queue Data_In; held stable from WRITE until next WRITE
//  overflow       out  1         sticky: a press was dropped because fifo_full=1
//  clr_ovf        in   1         synchronous clear of overflow
// BEHAVIOUR
//  Reset (rst=0, async): state=SCAN, kp_col=4'b1110, tick counter=0, fifo_cs=0, fifo_insert=0,
//   fifo_data=0, overflow=0. Reset mid-press discards the press; no write occurs.
//  kp_row passes a 2-FF synchroniser; all decisions use the synced value (2-cycle input latency).
//  Tick: counter counts 0..SCAN_DIV-1, tick=1 for one cycle at SCAN_DIV-1; free-running in all states.
//  FSM:
//   SCAN: on tick, if synced row==4'b1111 rotate kp_col left (1110->1101->1011->0111->1110);
//    else latch (r,c), r = lowest active row index, c = active column; -> DEBOUNCE, cnt=1.
//   DEBOUNCE: kp_col held. Each tick: row r still low -> cnt++; else -> SCAN (column unchanged).
//    cnt==DEBOUNCE_SCANS -> WRITE. DEBOUNCE_SCANS=1 goes straight to WRITE on the next cycle.
//   WRITE (1 cycle): fifo_full=0 -> fifo_cs=1, fifo_insert=1, fifo_data=code;
//    fifo_full=1 -> no pulse, overflow<=1. -> RELEASE, cnt=0.
//   RELEASE: kp_col held. Each tick: row r high -> cnt++ else cnt=0. cnt==DEBOUNCE_SCANS -> SCAN.
//  Code map (r,c): row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 E(*) 0 F(#) D.
//  Other keys pressed while one is held are ignored until RELEASE completes.
//  clr_ovf and a simultaneous dropped write: set wins (overflow stays 1).
//  fifo_cs never asserted two consecutive cycles; min spacing between writes >= SCAN_DIV cycles.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in RELEASE, key held continuously REPEAT_DELAY ticks -> WRITE again
//   (same code, same full/overflow rule), then every REPEAT_RATE ticks while held; release path unchanged.
//  Not defined: exactly one write per press; REPEAT_* unused; no repeat counter synthesised.
// STRUCTURE
//  Package keypad_pkg: state enum {SCAN, DEBOUNCE, WRITE, RELEASE}, 16-entry code map constant,
//   column reset value 4'b1110.
//  Sub-module keypad_scan_tick: SCAN_DIV prescaler producing tick; all else in keypad_fifo_writer.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2, bench keypad model, queue model with Full)
//  Press r1,c2 for 20 ticks, release -> exactly one fifo_cs pulse, fifo_insert=1, fifo_data=8'h06.
//  Bounce r0,c0 low 1 tick, high 1 tick, repeat 5x, then hold -> single write 8'h01 only after hold.
//  fifo_full=1, press r3,c1 -> no fifo_cs, overflow=1; clr_ovf pulse -> overflow=0.
//  Press r0,c3 and r2,c3 together -> one write 8'h0A; r2 ignored until both released.
//  rst=0 mid-DEBOUNCE -> kp_col=4'b1110, fifo_cs=0 immediately, no write after rst=1 without a new press.
//  KEYPAD_REPEAT_EN, REPEAT_DELAY=6, REPEAT_RATE=3, hold r3,c2 15 ticks -> writes 8'h0F at accept,
//   +6, +9, +12, +15 ticks; without macro -> one write.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad-to-queue writer.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN (see keypad_fifo_writer.sv).
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StWrite,
        StRelease
    } state_e;

    // Column drive after reset: column 0 pulled low.
    localparam logic [3:0] ColReset = 4'b1110;

    // Key code per (row, col), entry index {row, col}; entry 0 in the LSBs.
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
    localparam logic [63:0] CodeMap = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(logic [1:0] row, logic [1:0] col);
        return CodeMap[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_fifo_writer_if.sv
// Write side of the 16x8 queue: chip select, insert/delete select, data and Full.
interface keypad_fifo_writer_if #(
    parameter int unsigned DataWide = 8
);
    logic                full;
    logic                cs;
    logic                insert;
    logic [DataWide-1:0] data;

    modport master (input full, output cs, output insert, output data);
    modport slave  (output full, input cs, input insert, input data);
endinterface

// File: rtl/keypad_scan_tick.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks (column dwell time).
module keypad_scan_tick #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CntW = $clog2(SCAN_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Wrap the counter at SCAN_DIV-1 and flag that cycle as the tick.
    always_comb begin
        tick  = (cnt_q == CntW'(SCAN_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // Prescaler state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_fifo_writer.sv
// Scans a 4x4 active-low keypad, debounces presses and inserts one key code per accepted
// press into the queue. Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_fifo_writer
    import keypad_pkg::*;
#(
    parameter int unsigned DataWide       = 8,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  kp_row,
    output logic [3:0]                  kp_col,
    keypad_fifo_writer_if.master        fifo,
    output logic                        overflow,
    input  logic                        clr_ovf
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

    logic                tick;
    logic [3:0]          row_meta_q, row_sync_q;
    state_e              state_q, state_d;
    logic [3:0]          col_q, col_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DataWide-1:0] data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                cs, insert;
    logic                key_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RepW-1:0] rep_target;
    logic            rep_armed_q, rep_armed_d;
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    // Lowest-numbered row that reads low.
    function automatic logic [1:0] lowest_low_row(logic [3:0] row);
        if (!row[0]) return 2'd0;
        if (!row[1]) return 2'd1;
        if (!row[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Index of the column currently driven low.
    function automatic logic [1:0] driven_col(logic [3:0] col);
        case (col)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    keypad_scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp_row;
            row_sync_q <= row_meta_q;
        end
    end

    assign key_low = ~row_sync_q[row_idx_q];

    // Scan / debounce / write / release sequencing and the queue write strobe.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        cs        = 1'b0;
        insert    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_target  = rep_armed_q ? RepW'(REPEAT_RATE) : RepW'(REPEAT_DELAY);
`endif
        // A dropped write in the same cycle overrides the clear below.
        if (clr_ovf) ovf_d = 1'b0;

        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (row_sync_q == 4'hF) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        row_idx_d = lowest_low_row(row_sync_q);
                        col_idx_d = driven_col(col_q);
                        cnt_d     = CntW'(1);
                        state_d   = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (cnt_q == CntW'(DEBOUNCE_SCANS)) begin
                    data_d  = DataWide'(key_code(row_idx_q, col_idx_q));
                    state_d = StWrite;
`ifdef KEYPAD_REPEAT_EN
                    rep_armed_d = 1'b0;
`endif
                end else if (tick) begin
                    if (key_low) cnt_d = cnt_q + CntW'(1);
                    else         state_d = StScan;
                end
            end
            StWrite: begin
                if (!fifo.full) begin
                    cs     = 1'b1;
                    insert = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = StRelease;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_d = '0;
`endif
            end
            StRelease: begin
                if (cnt_q == CntW'(DEBOUNCE_SCANS)) begin
                    state_d = StScan;
                end else if (tick) begin
                    if (!key_low) cnt_d = cnt_q + CntW'(1);
                    else          cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                    // Held ticks must be uninterrupted; any high sample restarts the count.
                    if (key_low) begin
                        rep_cnt_d = rep_cnt_q + RepW'(1);
                        if (rep_cnt_q + RepW'(1) == rep_target) begin
                            rep_armed_d = 1'b1;
                            state_d     = StWrite;
                        end
                    end else begin
                        rep_cnt_d = '0;
                    end
`endif
                end
            end
            default: state_d = StScan;
        endcase
    end

    // Control state, latched key position, data and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StScan;
            col_q     <= ColReset;
            row_idx_q <= '0;
            col_idx_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat hold counter and first-repeat-done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    assign kp_col      = col_q;
    assign overflow    = ovf_q;
    assign fifo.cs     = cs;
    assign fifo.insert = insert;
    assign fifo.data   = data_q;

endmodule

// File: tb/tb_keypad_fifo_writer.sv
// Bench for keypad_fifo_writer: keypad matrix model, write monitor, expected-write scoreboard.
module tb_keypad_fifo_writer;
    localparam int unsigned DW = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned DS = 2;
    localparam int unsigned RD = 6;
    localparam int unsigned RR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  kp_row;
    logic [3:0]  kp_col;
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic        full_drv = 1'b0;
    logic [15:0] pressed = '0;

    keypad_fifo_writer_if #(.DataWide(DW)) fifo_if ();
    assign fifo_if.full = full_drv;

    keypad_fifo_writer #(
        .DataWide      (DW),
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .kp_row  (kp_row),
        .kp_col  (kp_col),
        .fifo    (fifo_if),
        .overflow(overflow),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its row to its column; rows pulled up.
    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
    end

    // Printed keypad legend, index row*4+col.
    logic [3:0] key_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  obs_q [$];
    longint      obs_t [$];
    logic [7:0]  exp_q [$];
    longint      cyc = 0;
    logic        prev_cs = 1'b0;
    logic        ovf_m = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check_eq("insert_tracks_cs", {31'd0, fifo_if.insert}, {31'd0, fifo_if.cs});
            if (fifo_if.cs) begin
                check_eq("no_back_to_back_cs", {31'd0, prev_cs}, 32'd0);
                obs_q.push_back(fifo_if.data);
                obs_t.push_back(cyc);
            end
            prev_cs = fifo_if.cs;
        end else begin
            prev_cs = 1'b0;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * SD) @(posedge clk);
    endtask

    // Called right after a rising edge; changes keys just after it.
    task automatic set_keys(input logic [15:0] k);
        #1 pressed = k;
    endtask

    task automatic press(input int key, input int hold, input int rel);
        set_keys(16'(1) << key);
        wait_ticks(hold);
        set_keys('0);
        wait_ticks(rel);
    endtask

    task automatic model_press(input int key, input logic full);
        if (full) ovf_m = 1'b1;
        else      exp_q.push_back({4'h0, key_code[key]});
    endtask

    task automatic score(input string tag);
        int n;
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_data"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        check_eq({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf_m});
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        int key;
        logic full;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_col", {28'd0, kp_col}, 32'hE);
        check_eq("rst_cs", {31'd0, fifo_if.cs}, 32'd0);
        check_eq("rst_insert", {31'd0, fifo_if.insert}, 32'd0);
        check_eq("rst_data", {24'd0, fifo_if.data}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        @(posedge clk);

        // Single clean press r1,c2.
        press(6, 20, 10);
        model_press(6, 1'b0);
        score("single_press");

        // Bouncing contact r0,c0, then a solid hold.
        for (int i = 0; i < 5; i++) begin
            set_keys(16'h0001);
            wait_ticks(1);
            set_keys('0);
            wait_ticks(1);
        end
        wait_ticks(4);
        check_eq("bounce_no_write", obs_q.size(), 0);
        press(0, 20, 10);
        model_press(0, 1'b0);
        score("bounce_hold");

        // Queue full: drop and set overflow, then clear it.
        full_drv = 1'b1;
        press(13, 20, 10);
        model_press(13, 1'b1);
        score("full_drop");
        full_drv = 1'b0;
        #1 clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        ovf_m = 1'b0;
        @(posedge clk);
        check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Two keys in column 3: lower row wins, the other is ignored.
        set_keys(16'h0808);
        wait_ticks(20);
        set_keys('0);
        wait_ticks(10);
        exp_q.push_back(8'h0A);
        score("two_keys");

        // Reset while debouncing r0,c1.
        @(posedge clk);
        #1 rst = 1'b0;
        pressed = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        pressed = 16'h0002;
        repeat (10) @(posedge clk);
        #2;
        check_eq("pre_rst_col", {28'd0, kp_col}, 32'hD);
        check_eq("pre_rst_no_write", obs_q.size(), 0);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_col", {28'd0, kp_col}, 32'hE);
        check_eq("mid_rst_cs", {31'd0, fifo_if.cs}, 32'd0);
        check_eq("mid_rst_data", {24'd0, fifo_if.data}, 32'd0);
        pressed = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        wait_ticks(20);
        score("reset_discard");

        // Long hold r3,c2: auto-repeat timing when enabled, single write otherwise.
        base = obs_q.size();
        set_keys(16'h4000);
        guard = 0;
        while (obs_q.size() == base && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check_eq("hold_first_write_seen", {31'd0, guard < 200}, 32'd1);
        repeat (66) @(posedge clk);
        set_keys('0);
        wait_ticks(10);
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h0F);
        if (obs_t.size() == 5) begin
            check_eq("repeat_gap0_ticks", 32'((obs_t[1] - obs_t[0] + SD / 2) / SD), RD);
            for (int i = 1; i < 4; i++)
                check_eq("repeat_gap_ticks", 32'((obs_t[i+1] - obs_t[i] + SD / 2) / SD), RR);
        end
`else
        exp_q.push_back(8'h0F);
`endif
        score("hold");

        // Randomized presses against the scoreboard.
        for (int i = 0; i < 16; i++) begin
            key  = $urandom_range(0, 15);
            full = ($urandom_range(0, 3) == 0);
            if (ovf_m && $urandom_range(0, 1) == 1) begin
                #1 clr_ovf = 1'b1;
                @(posedge clk);
                #1 clr_ovf = 1'b0;
                ovf_m = 1'b0;
                @(posedge clk);
            end
            full_drv = full;
            press(key, $urandom_range(12, 20), $urandom_range(8, 12));
            model_press(key, full);
            score("random");
            full_drv = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
